// File: rtl/alu_cmd_feeder.sv
// ALU command queue feeding one-hot ops through LOAD/HOLD issue phases.
// Optional one-hot wr_op check: define ALU_CMD_FEEDER_ONEHOT_CHK_EN.
module alu_cmd_feeder #(
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       on,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_num1,
  input  logic [7:0]                 wr_num2,
  input  logic [6:0]                 wr_op,
  output logic [7:0]                 num1,
  output logic [7:0]                 num2,
  output logic [6:0]                 out_sel,
  output logic [2:0]                 in_sel,
  output logic                       full,
  output logic                       empty,
  output logic                       busy,
  output logic                       issue_done,
  output logic                       overflow,
  output logic                       cmd_err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  logic [22:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [1:0]    state;
  logic [HW-1:0] hcnt;
  logic          op_ok;
  logic          push;
  logic          pop;
  logic          hold_end;
  logic [CW-1:0] cnt_nxt;

`ifdef ALU_CMD_FEEDER_ONEHOT_CHK_EN
  assign op_ok = (wr_op != '0) && ((wr_op & (wr_op - 7'd1)) == '0);
`else
  assign op_ok = 1'b1;
`endif

  assign push     = wr_en && !full && op_ok;
  assign hold_end = (state == HOLD) && (hcnt == HOLD_LAST);
  assign pop      = on && !empty && ((state == IDLE) || hold_end);

  always_comb begin
    cnt_nxt = count;
    if (push && !pop)
      cnt_nxt = count + CW'(1);
    else if (pop && !push)
      cnt_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wptr] <= {wr_num1, wr_num2, wr_op};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      state      <= IDLE;
      hcnt       <= '0;
      num1       <= '0;
      num2       <= '0;
      out_sel    <= '0;
      in_sel     <= 3'b001;
      busy       <= 1'b0;
      issue_done <= 1'b0;
      overflow   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      count    <= cnt_nxt;
      full     <= (cnt_nxt == FULL_CNT);
      empty    <= (cnt_nxt == '0);
      overflow <= wr_en && full;
`ifdef ALU_CMD_FEEDER_ONEHOT_CHK_EN
      cmd_err  <= wr_en && !full && !op_ok;
`else
      cmd_err  <= 1'b0;
`endif
      if (push)
        wptr <= wptr + AW'(1);
      if (pop) begin
        rptr                    <= rptr + AW'(1);
        {num1, num2, out_sel}   <= mem[rptr];
      end
      issue_done <= 1'b0;
      in_sel     <= 3'b100;
      // pop only fires from IDLE or the last HOLD cycle
      unique case (1'b1)
        pop: begin
          state  <= LOAD;
          in_sel <= 3'b010;
          busy   <= 1'b1;
        end
        (state == LOAD): begin
          state      <= HOLD;
          hcnt       <= '0;
          issue_done <= (HOLD_LAST == '0);
          busy       <= 1'b1;
        end
        (state == HOLD) && !hold_end: begin
          hcnt       <= hcnt + HW'(1);
          issue_done <= ((hcnt + HW'(1)) == HOLD_LAST);
          busy       <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_feeder.sv
// Directed bench for alu_cmd_feeder (DEPTH=4, HOLD_CYC=2).
// Expected values are hand-computed per cycle.
module tb_alu_cmd_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       on;
  logic       wr_en;
  logic [7:0] wr_num1;
  logic [7:0] wr_num2;
  logic [6:0] wr_op;
  logic [7:0] num1;
  logic [7:0] num2;
  logic [6:0] out_sel;
  logic [2:0] in_sel;
  logic       full;
  logic       empty;
  logic       busy;
  logic       issue_done;
  logic       overflow;
  logic       cmd_err;
  logic [2:0] count;

  int n_run  = 0;
  int n_fail = 0;

  alu_cmd_feeder #(.DEPTH(4), .HOLD_CYC(2)) dut (
    .clk(clk), .rst(rst), .on(on), .wr_en(wr_en),
    .wr_num1(wr_num1), .wr_num2(wr_num2), .wr_op(wr_op),
    .num1(num1), .num2(num2), .out_sel(out_sel),
    .in_sel(in_sel), .full(full), .empty(empty),
    .busy(busy), .issue_done(issue_done),
    .overflow(overflow), .cmd_err(cmd_err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [7:0] b,
                    input logic [6:0] op);
    wr_en   = 1'b1;
    wr_num1 = a;
    wr_num2 = b;
    wr_op   = op;
  endtask

  // one full issue: LOAD cycle then two HOLD cycles
  task automatic issue(input string tag,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [6:0] op,
                       input int cnt);
    tick();
    wr_en = 1'b0;
    chk({tag, ".ld_in_sel"}, in_sel, 3'b010);
    chk({tag, ".num1"}, num1, a);
    chk({tag, ".num2"}, num2, b);
    chk({tag, ".out_sel"}, out_sel, op);
    chk({tag, ".count"}, count, cnt);
    chk({tag, ".ld_busy"}, busy, 1);
    tick();
    chk({tag, ".h1_in_sel"}, in_sel, 3'b100);
    chk({tag, ".h1_done"}, issue_done, 0);
    chk({tag, ".h1_busy"}, busy, 1);
    tick();
    chk({tag, ".h2_in_sel"}, in_sel, 3'b100);
    chk({tag, ".h2_done"}, issue_done, 1);
    chk({tag, ".h2_busy"}, busy, 1);
  endtask

  initial begin
    rst     = 1'b1;
    on      = 1'b0;
    wr_en   = 1'b0;
    wr_num1 = '0;
    wr_num2 = '0;
    wr_op   = '0;
    @(negedge clk);
    wr(8'hEE, 8'hEE, 7'b0000001);
    tick();
    wr_en = 1'b0;
    chk("rst.in_sel", in_sel, 3'b001);
    chk("rst.count", count, 0);
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.busy", busy, 0);
    chk("rst.num1", num1, 0);
    chk("rst.out_sel", out_sel, 0);
    chk("rst.flags", {issue_done, overflow, cmd_err}, 0);
    rst = 1'b0;
    tick();
    chk("idle.in_sel", in_sel, 3'b100);
    chk("rst.wr_dropped", count, 0);

    // single command
    on = 1'b1;
    wr(8'h57, 8'h1A, 7'b1000000);
    tick();
    wr_en = 1'b0;
    chk("t1.count_push", count, 1);
    issue("t1", 8'h57, 8'h1A, 7'b1000000, 0);
    tick();
    chk("t1.idle_in_sel", in_sel, 3'b100);
    chk("t1.idle_busy", busy, 0);
    chk("t1.idle_done", issue_done, 0);
    chk("t1.idle_hold_num1", num1, 8'h57);

    // fill with on=0, entries cross the pointer wrap
    on = 1'b0;
    wr(8'h02, 8'h04, 7'b1000000); tick();
    wr(8'h07, 8'h02, 7'b0100000); tick();
    wr(8'h11, 8'h22, 7'b0000001); tick();
    wr(8'h33, 8'h44, 7'b0001000); tick();
    chk("t2.full", full, 1);
    chk("t2.count4", count, 4);
    chk("t2.busy_off", busy, 0);
    wr(8'h99, 8'h99, 7'b0000010); tick();
    wr_en = 1'b0;
    chk("t2.overflow", overflow, 1);
    chk("t2.count_stays", count, 4);
    tick();
    chk("t2.overflow_clr", overflow, 0);

    // back-to-back issue, push+pop at count=2, FIFO order
    on = 1'b1;
    issue("b0", 8'h02, 8'h04, 7'b1000000, 3);
    issue("b1", 8'h07, 8'h02, 7'b0100000, 2);
    wr(8'h55, 8'h66, 7'b0000010);
    issue("b2", 8'h11, 8'h22, 7'b0000001, 2);
    issue("b3", 8'h33, 8'h44, 7'b0001000, 1);
    issue("b4", 8'h55, 8'h66, 7'b0000010, 0);
    tick();
    chk("b.idle_busy", busy, 0);
    chk("b.idle_empty", empty, 1);
    chk("b.idle_in_sel", in_sel, 3'b100);

    // reset in HOLD aborts the command
    wr(8'h10, 8'h20, 7'b0000100);
    tick();
    wr_en = 1'b0;
    tick();
    chk("t4.load", in_sel, 3'b010);
    tick();
    chk("t4.hold1", in_sel, 3'b100);
    rst = 1'b1;
    wr(8'h77, 8'h77, 7'b0000001);
    tick();
    wr_en = 1'b0;
    chk("t4.rst_in_sel", in_sel, 3'b001);
    chk("t4.rst_done", issue_done, 0);
    chk("t4.rst_count", count, 0);
    chk("t4.rst_busy", busy, 0);
    rst = 1'b0;
    on  = 1'b0;
    tick();
    chk("t4.post_in_sel", in_sel, 3'b100);
    chk("t4.post_done", issue_done, 0);
    chk("t4.post_count", count, 0);

    // non-one-hot op
    wr(8'h01, 8'h02, 7'b0000011);
    tick();
    wr_en = 1'b0;
`ifdef ALU_CMD_FEEDER_ONEHOT_CHK_EN
    chk("t5.cmd_err", cmd_err, 1);
    chk("t5.count", count, 0);
`else
    chk("t5.cmd_err", cmd_err, 0);
    chk("t5.count", count, 1);
`endif
    tick();
    chk("t5.cmd_err_clr", cmd_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
